// File: rtl/mem_block_responder.sv
// Memory-side responder: one-cycle single-word writes and 8-word block reads
// returned one word per cycle after LATENCY cycles. Define MEM_CWF_EN for critical-word-first bursts.
module mem_block_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        wr_ack,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic [2:0]  resp_word,
    output logic        resp_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
    } state_t;

    // WAIT holds for LATENCY-1 cycles, counting down to zero.
    localparam logic [2:0] LAT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    logic [15:0] mem_q [2**ADDR_W];

    state_t              state_q, state_d;
    logic [2:0]          lat_q, lat_d;
    logic [2:0]          word_q, word_d;
    logic [2:0]          first_q, first_d;
    logic [ADDR_W-4:0]   base_q, base_d;
    logic [15:0]         rdata_q;
    logic                wr_ack_q, wr_ack_d;

    logic                rd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_idx;
    logic [ADDR_W-4:0]   req_base;
    logic [2:0]          req_first;
    logic [2:0]          last_word;
    logic                unused_addr;

    assign wr_idx   = req_addr[ADDR_W:1];
    assign req_base = req_addr[ADDR_W:4];
`ifdef MEM_CWF_EN
    assign req_first = req_addr[3:1];
`else
    assign req_first = 3'd0;
`endif
    assign unused_addr = ^{req_addr[15:ADDR_W+1], req_addr[0]};

    // The eighth delivered word is the one just before the starting word.
    assign last_word = 3'(first_q + 3'd7);

    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        word_d   = word_q;
        first_d  = first_q;
        base_d   = base_q;
        wr_ack_d = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_en) begin
                    if (req_write) begin
                        wr_en    = 1'b1;
                        wr_ack_d = 1'b1;
                    end else begin
                        base_d  = req_base;
                        first_d = req_first;
                        word_d  = req_first;
                        if (LATENCY == 1) begin
                            state_d = S_XFER;
                            rd_en   = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                            lat_d   = LAT_INIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (lat_q == 3'd0) begin
                    state_d = S_XFER;
                    rd_en   = 1'b1;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_XFER: begin
                if (word_q == last_word) begin
                    state_d = S_IDLE;
                end else begin
                    word_d = word_q + 3'd1;
                    rd_en  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rdata_q is loaded one edge ahead so it lines up with the word shown by word_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            lat_q    <= 3'd0;
            word_q   <= 3'd0;
            first_q  <= 3'd0;
            base_q   <= '0;
            wr_ack_q <= 1'b0;
            rdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            word_q   <= word_d;
            first_q  <= first_d;
            base_q   <= base_d;
            wr_ack_q <= wr_ack_d;
            if (rd_en) rdata_q <= mem_q[{base_d, word_d}];
        end
    end

    // Array contents survive reset; writes are only taken outside reset.
    always_ff @(posedge clk) begin
        if (rst && wr_en) mem_q[wr_idx] <= req_wdata;
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign wr_ack     = wr_ack_q;
    assign resp_valid = (state_q == S_XFER);
    assign resp_data  = resp_valid ? rdata_q : 16'h0000;
    assign resp_word  = resp_valid ? word_q : 3'd0;
    assign resp_last  = resp_valid && (word_q == last_word);

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder: reset, writes, bursts, ignored requests,
// mid-burst reset, address aliasing and (with MEM_CWF_EN) critical-word-first order.
module tb_mem_block_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        wr_ack;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [2:0]  resp_word;
    logic        resp_last;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] model [8];

    always #5 clk = ~clk;

    mem_block_responder #(.ADDR_W(12), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_en     (req_en),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .wr_ack     (wr_ack),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_word  (resp_word),
        .resp_last  (resp_last),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_data"},  32'(resp_data),  32'd0);
        chk({tag, "_word"},  32'(resp_word),  32'd0);
        chk({tag, "_last"},  32'(resp_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_ready"}, 32'(req_ready),  32'd1);
    endtask

    // Issues a block read and follows it cycle by cycle. inject drives a write
    // while busy (must be ignored); abort_k >= 0 resets during that data cycle.
    task automatic burst(input logic [15:0] addr, input bit inject, input int abort_k);
        int w;
        logic [2:0] wd;
`ifdef MEM_CWF_EN
        w = int'(addr[3:1]);
`else
        w = 0;
`endif
        req_en = 1'b1; req_write = 1'b0; req_addr = addr;
        tick();
        req_en = 1'b0;
        if (inject) begin
            req_en = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'hBEEF;
        end
        chk("rd_busy",  32'(busy),      32'd1);
        chk("rd_ready", 32'(req_ready), 32'd0);
        for (int c = 1; c < LAT; c++) begin
            chk("lat_valid",  32'(resp_valid), 32'd0);
            chk("lat_wr_ack", 32'(wr_ack),     32'd0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            wd = 3'(w + k);
            chk("d_valid",  32'(resp_valid), 32'd1);
            chk("d_word",   32'(resp_word),  32'(wd));
            chk("d_data",   32'(resp_data),  32'(model[wd]));
            chk("d_last",   32'(resp_last),  32'(k == 7));
            chk("d_wr_ack", 32'(wr_ack),     32'd0);
            if (k == abort_k) begin
                rst = 1'b0;
                tick();
                chk_idle("abort");
                chk("abort_wr_ack", 32'(wr_ack), 32'd0);
                rst = 1'b1;
                return;
            end
            tick();
        end
        req_en = 1'b0;
        chk_idle("done");
        chk("done_wr_ack", 32'(wr_ack), 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_en = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("rst");
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            req_en = 1'b1; req_write = 1'b1;
            req_addr = 16'(16'h0040 + 2 * i);
            req_wdata = 16'(16'h1000 + i);
            model[i] = 16'(16'h1000 + i);
            tick();
            chk("wr_ack",   32'(wr_ack),    32'd1);
            chk("wr_ready", 32'(req_ready), 32'd1);
        end
        req_en = 1'b0;
        tick();
        chk("wr_ack_end", 32'(wr_ack), 32'd0);

        burst(16'h0040, 1'b0, -1);
        burst(16'h0040, 1'b1, -1);
        burst(16'h0040, 1'b0, -1);

        burst(16'h0040, 1'b0, 2);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("post_abort_valid", 32'(resp_valid), 32'd0);
            chk("post_abort_last",  32'(resp_last),  32'd0);
        end
        burst(16'h0040, 1'b0, -1);

        burst(16'h004A, 1'b0, -1);

        // 0xE041 aliases onto word 0x020 (upper bits and byte bit 0 dropped).
        req_en = 1'b1; req_write = 1'b1; req_addr = 16'hE041; req_wdata = 16'hA5A5;
        model[0] = 16'hA5A5;
        tick();
        req_en = 1'b0;
        chk("alias_wr_ack", 32'(wr_ack), 32'd1);
        burst(16'h0046, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Memory-side responder for the cache miss/fill path. It sits between the cache miss interface and the unified main memory.
- It accepts single-word write requests, and burst-read requests that return a full 8-word (16-byte) cache block, one word per cycle, after a fixed access latency.
- Each returned word is tagged with its word number, so the cache FSM can steer it into its data array.

Parameters:
- ADDR_W, 12, word-address bits held in the array (array depth = 2^ADDR_W 16-bit words).
- LATENCY, 4, cycles from request accept to first returned word; legal range 1..8.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- req_en  input  1  request valid (driven by the cache interface mem_en).
- req_write  input  1  1 = single-word write, 0 = 8-word block read.
- req_addr  input  16  byte address; bit 0 ignored.
- req_wdata  input  16  write data.
- req_ready  output  1  responder can accept a request this cycle.
- wr_ack  output  1  one-cycle pulse confirming a completed write.
- resp_valid  output  1  resp_data holds a valid read word.
- resp_data  output  16  returned word.
- resp_word  output  3  word number within the block (matches Word_Num).
- resp_last  output  1  high with the final word of a burst.
- busy  output  1  high while a burst is outstanding.

Behaviour:
- Word index = req_addr[ADDR_W:1]. Upper address bits are ignored, so addresses alias modulo the array size.
- Block base = word index with its low 3 bits cleared.
- Request acceptance: a request is accepted on a rising edge where rst=1, req_en=1 and req_ready=1. Requests presented while req_ready=0 are ignored, not queued.
- Write:
  - The array word is updated at the accept edge.
  - wr_ack=1 for exactly the next cycle.
  - req_ready stays 1, so back-to-back writes run one per cycle.
- Burst read accepted at edge T:
  - busy=1 and req_ready=0 from T+1.
  - Word k (k=0..7) is read from base+k.
  - resp_valid=1, resp_data=mem[base+k] and resp_word=k in cycle T+LATENCY+k; the 8 valid cycles are contiguous.
  - resp_last=1 only with k=7.
  - busy=0 and req_ready=1 in cycle T+LATENCY+8.
- Read data reflects all writes accepted before T.
- State machine:
  - IDLE → WAIT on burst accept. WAIT counts LATENCY-1 cycles; with LATENCY=1 it is skipped and the FSM goes directly to XFER.
  - WAIT → XFER. XFER lasts 8 cycles, driven by a 3-bit word counter.
  - XFER → IDLE after word 7 is delivered.
  - Writes never leave IDLE.
- Counters: the latency counter is 3 bits; the word counter is 3 bits and wraps 7→0. The wrap is only reachable in the optional mode.
- When resp_valid=0: resp_data=16'h0000, resp_word=0, resp_last=0.
- Reset values (rst=0 at an edge):
  - State IDLE; req_ready=1, wr_ack=0, resp_valid=0, resp_data=0, resp_word=0, resp_last=0, busy=0.
  - Array contents are NOT reset.
- Reset mid-burst aborts the burst immediately. No further words are delivered; the next cycle shows reset values.
- req_en with X on req_write while req_ready=1 is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro: MEM_CWF_EN (critical-word-first).
- Defined: a burst starts at the requested word w = req_addr[3:1]. Word order is w, w+1, … modulo 8, and resp_word carries the actual word number. resp_last marks the 8th word delivered, i.e. word (w+7) mod 8. Timing is unchanged.
- Undefined: req_addr[3:1] is ignored and bursts always return words 0..7 in order.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → req_ready=1, busy=0, resp_valid=0, resp_data=0.
- Writes: write 0x1000+i to byte addresses 0x0040+2i for i=0..7 in consecutive cycles → 8 wr_ack pulses, each one cycle after its accept; req_ready stays 1.
- Burst read at 0x0040 accepted at edge T (LATENCY=4) → resp_valid in cycles T+4..T+11 with data 0x1000..0x1007 and resp_word 0..7; resp_last only at T+11; req_ready=1 at T+12.
- Requests during burst: assert req_en with a write to 0x0040 while busy=1 → ignored; a subsequent re-read still returns 0x1000; no wr_ack.
- Reset mid-burst: rst=0 during the 3rd data cycle → outputs at reset values the next cycle; no resp_last is ever seen; a new burst afterwards completes normally.
- MEM_CWF_EN: burst read at 0x004A (w=5) → resp_word sequence 5,6,7,0,1,2,3,4, data 0x1005,0x1006,0x1007,0x1000,…,0x1004, resp_last with word 4. Without the macro the same request returns words 0..7.
